// File: rtl/aes_byte_seq_ctrl.sv
// aes_byte_seq_ctrl: buffers one 16-byte data/key block, bursts it into a byte-serial
// AES-128 core, captures the cipher bytes CORE_LAT cycles later and streams them out.
//
// state | meaning
// LOAD  | accepting input byte pairs into the data/key buffers
// RUN   | feeding the core (cyc 0..15) and capturing cipher (cyc CORE_LAT..CORE_LAT+15)
// DRAIN | returning the 16 captured cipher bytes on the output stream
module aes_byte_seq_ctrl #(
    parameter int CORE_LAT = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [7:0] in_key,
    output logic [7:0] core_data,
    output logic [7:0] core_key,
    output logic       core_start,
    input  logic [7:0] core_chiper,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] CAP_FIRST = 8'(CORE_LAT);
    localparam logic [7:0] CAP_LAST  = 8'(CORE_LAT + 15);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] cyc_q, cyc_d;
    logic       in_ready_q, in_ready_d;
    logic [7:0] out_data_q, out_data_d;

    logic [7:0] data_buf_q   [16];
    logic [7:0] data_buf_d   [16];
    logic [7:0] key_buf_q    [16];
    logic [7:0] key_buf_d    [16];
    logic [7:0] cipher_buf_q [16];
    logic [7:0] cipher_buf_d [16];

    logic [3:0] cap_idx;

    assign cap_idx = 4'(cyc_q - CAP_FIRST);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cyc_d        = cyc_q;
        out_data_d   = out_data_q;
        data_buf_d   = data_buf_q;
        key_buf_d    = key_buf_q;
        cipher_buf_d = cipher_buf_q;
        core_data    = 8'h00;
        core_key     = 8'h00;
        core_start   = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    data_buf_d[idx_q] = in_data;
                    key_buf_d[idx_q]  = in_key;
                    idx_d             = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        cyc_d   = 8'd0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy  = 1'b1;
                cyc_d = cyc_q + 8'd1;
                if (cyc_q < 8'd16) begin
                    core_data  = data_buf_q[cyc_q[3:0]];
                    core_key   = key_buf_q[cyc_q[3:0]];
                    core_start = (cyc_q == 8'd0);
                end
                // Capture runs off the same counter as the feed, so the two may overlap.
                if (cyc_q >= CAP_FIRST) begin
                    cipher_buf_d[cap_idx] = core_chiper;
                end
                if (cyc_q == CAP_LAST) begin
                    cyc_d      = cyc_q;
                    idx_d      = 4'd0;
                    out_data_d = cipher_buf_q[0];
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        done    = 1'b1;
                        state_d = LOAD;
                    end else begin
                        out_data_d = cipher_buf_q[idx_q + 4'd1];
                    end
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = 4'd0;
                cyc_d   = 8'd0;
            end
        endcase

        // Registered so in_ready stays low during reset and drops the cycle after the 16th accept.
        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            idx_q      <= 4'd0;
            cyc_q      <= 8'd0;
            in_ready_q <= 1'b0;
            out_data_q <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                data_buf_q[i]   <= 8'h00;
                key_buf_q[i]    <= 8'h00;
                cipher_buf_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cyc_q        <= cyc_d;
            in_ready_q   <= in_ready_d;
            out_data_q   <= out_data_d;
            data_buf_q   <= data_buf_d;
            key_buf_q    <= key_buf_d;
            cipher_buf_q <= cipher_buf_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_aes_byte_seq_ctrl.sv
// Bench for aes_byte_seq_ctrl: two instances (CORE_LAT 40 and 16) driven through a shared,
// selectable stream interface, each paired with a stand-in byte-serial core model.
module tb_aes_byte_seq_ctrl;

    localparam int LAT0 = 40;
    localparam int LAT1 = 16;

    localparam logic [127:0] FIPS_PT  = 128'h328831E0_435A3137_F6309807_A88DA234;
    localparam logic [127:0] FIPS_KEY = 128'h2B28AB09_7EAEF7CF_15D2154F_16A6883C;
    localparam logic [127:0] FIPS_CT  = 128'h3902DC19_25DC116A_8409850B_1DFB9732;

    localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] K1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] B2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    localparam logic [127:0] K2 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] B3 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    localparam logic [127:0] K3 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    localparam logic [127:0] B4 = 128'h55AA55AA_12345678_9ABCDEF0_0F1E2D3C;
    localparam logic [127:0] K4 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] B5 = 128'hC0FFEE00_BADC0DE5_13579BDF_2468ACE0;
    localparam logic [127:0] K5 = 128'h99887766_55443322_110FEDCB_A9876543;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, out_ready, sel;
    logic [7:0] in_data, in_key;

    logic       in_ready_v   [2];
    logic       out_valid_v  [2];
    logic [7:0] out_data_v   [2];
    logic       busy_v       [2];
    logic       done_v       [2];
    logic       core_start_v [2];
    logic [7:0] core_data_v  [2];
    logic [7:0] core_key_v   [2];
    logic [7:0] chip_v       [2] = '{8'h00, 8'h00};

    logic       in_ready_m, out_valid_m, busy_m, done_m, core_start_m;
    logic [7:0] out_data_m, core_data_m, core_key_m;

    int n_chk = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int cs_cnt = 0;
    int zero_viol = 0;
    int t_v [2] = '{1000, 1000};
    logic [127:0] rec_d [2];
    logic [127:0] rec_k [2];

    always #5 clk = ~clk;

    aes_byte_seq_ctrl #(.CORE_LAT(LAT0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(in_ready_v[0]),
        .in_data(in_data), .in_key(in_key),
        .core_data(core_data_v[0]), .core_key(core_key_v[0]), .core_start(core_start_v[0]),
        .core_chiper(chip_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready & ~sel), .out_data(out_data_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    aes_byte_seq_ctrl #(.CORE_LAT(LAT1)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(in_ready_v[1]),
        .in_data(in_data), .in_key(in_key),
        .core_data(core_data_v[1]), .core_key(core_key_v[1]), .core_start(core_start_v[1]),
        .core_chiper(chip_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready & sel), .out_data(out_data_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    assign in_ready_m   = in_ready_v[sel];
    assign out_valid_m  = out_valid_v[sel];
    assign out_data_m   = out_data_v[sel];
    assign busy_m       = busy_v[sel];
    assign done_m       = done_v[sel];
    assign core_start_m = core_start_v[sel];
    assign core_data_m  = core_data_v[sel];
    assign core_key_m   = core_key_v[sel];

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        return b[127 - 8*i -: 8];
    endfunction

    // Stand-in core: the real FIPS-197 answer for the FIPS vector, otherwise a keyed byte mix.
    function automatic logic [7:0] cipher_of(input logic [127:0] d, input logic [127:0] k, input int i);
        if (d == FIPS_PT && k == FIPS_KEY) return byte_of(FIPS_CT, i);
        return byte_of(d, i) ^ byte_of(k, i) ^ 8'(8'h3C + 7*i);
    endfunction

    function automatic logic [127:0] cipher_blk(input logic [127:0] d, input logic [127:0] k);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = cipher_of(d, k, i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Core models: te is the cycle index relative to the last core_start.
    always @(posedge clk) begin
        int te;
        int lat;
        for (int g = 0; g < 2; g++) begin
            lat = (g == 0) ? LAT0 : LAT1;
            te  = core_start_v[g] ? 0 : ((t_v[g] < 1000) ? t_v[g] + 1 : 1000);
            t_v[g] = te;
            if (te < 16) begin
                rec_d[g][127 - 8*te -: 8] = core_data_v[g];
                rec_k[g][127 - 8*te -: 8] = core_key_v[g];
            end else if (te < 1000 && (core_data_v[g] != 8'h00 || core_key_v[g] != 8'h00)) begin
                zero_viol++;
            end
            if (te + 1 >= lat && te + 1 <= lat + 15)
                chip_v[g] <= cipher_of(rec_d[g], rec_k[g], te + 1 - lat);
            else
                chip_v[g] <= 8'h00;
        end
    end

    always @(posedge clk) begin
        if (in_valid && in_ready_m) acc_cnt++;
        if (core_start_m) cs_cnt++;
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready_m, 1'b0);
        chk("rst_core_data", core_data_m, 8'h00);
        chk("rst_core_key", core_key_m, 8'h00);
        chk("rst_core_start", core_start_m, 1'b0);
        chk("rst_out_valid", out_valid_m, 1'b0);
        chk("rst_out_data", out_data_m, 8'h00);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("in_ready_at_release", in_ready_m, 1'b0);
        @(negedge clk);
        chk("in_ready_after_release", in_ready_m, 1'b1);
    endtask

    task automatic load_block(input logic [127:0] d, input logic [127:0] k, input bit gap);
        int i = 0;
        int budget = 0;
        bit tog = 1'b1;
        bit acc;
        while (i < 16 && budget < 500) begin
            in_valid = gap ? tog : 1'b1;
            tog      = ~tog;
            in_data  = byte_of(d, i);
            in_key   = byte_of(k, i);
            acc      = in_valid && in_ready_m;
            @(negedge clk);
            budget++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("load_count", i, 16);
        chk("core_start_after_load", core_start_m, 1'b1);
        chk("in_ready_in_run", in_ready_m, 1'b0);
        chk("core_byte0", core_data_m, byte_of(d, 0));
    endtask

    task automatic drain_block(input logic [127:0] exp, input int stall, input int n_stop,
                               output int run_len);
        int n = 0;
        int w = 0;
        int budget = 0;
        logic [7:0] held = 8'h00;
        run_len = 0;
        while (n < n_stop && budget < 3000) begin
            chk("busy_active", busy_m, 1'b1);
            chk("in_ready_active", in_ready_m, 1'b0);
            if (!out_valid_m) begin
                run_len++;
                out_ready = 1'b0;
            end else if (w < stall) begin
                out_ready = 1'b0;
                if (w > 0) chk("stall_hold", out_data_m, held);
                held = out_data_m;
                w++;
            end else begin
                out_ready = 1'b1;
                chk($sformatf("out_byte%0d", n), out_data_m, byte_of(exp, n));
                #1;
                chk($sformatf("done_at%0d", n), done_m, n == 15);
                n++;
                w = 0;
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        chk("drain_count", n, n_stop);
        if (n_stop == 16) begin
            chk("out_valid_after", out_valid_m, 1'b0);
            chk("in_ready_after", in_ready_m, 1'b1);
            chk("busy_after", busy_m, 1'b0);
            chk("out_data_held", out_data_m, byte_of(exp, 15));
        end
    endtask

    task automatic run_block(input logic [127:0] d, input logic [127:0] k, input bit gap,
                             input int stall, input int lat);
        int run_len;
        int acc_base;
        int cs_base;
        acc_base = acc_cnt;
        cs_base  = cs_cnt;
        load_block(d, k, gap);
        drain_block(cipher_blk(d, k), stall, 16, run_len);
        chk("run_len", run_len, lat + 16);
        chk("accepts", acc_cnt - acc_base, 16);
        chk("start_pulses", cs_cnt - cs_base, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_len;
        int acc_base;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_key = 8'h00;
        out_ready = 1'b0; sel = 1'b0;
        @(negedge clk);
        apply_reset();

        run_block(FIPS_PT, FIPS_KEY, 1'b0, 0, LAT0);
        chk("fips_ct_model", cipher_blk(FIPS_PT, FIPS_KEY), FIPS_CT);

        run_block(B1, K1, 1'b1, 0, LAT0);
        chk("feed_order_data", rec_d[0], B1);
        chk("feed_order_key", rec_k[0], K1);

        run_block(B2, K2, 1'b0, 3, LAT0);

        sel = 1'b1;
        run_block(B3, K3, 1'b0, 0, LAT1);
        chk("feed16_data", rec_d[1], B3);
        sel = 1'b0;

        load_block(B4, K4, 1'b0);
        repeat (20) @(negedge clk);
        apply_reset();
        run_block(B5, K5, 1'b0, 0, LAT0);

        load_block(B4, K4, 1'b0);
        drain_block(cipher_blk(B4, K4), 0, 5, run_len);
        apply_reset();
        run_block(FIPS_PT, FIPS_KEY, 1'b0, 1, LAT0);

        acc_base = acc_cnt;
        load_block(B3, K3, 1'b0);
        in_valid = 1'b1;
        in_data  = byte_of(B2, 0);
        in_key   = byte_of(K2, 0);
        drain_block(cipher_blk(B3, K3), 1, 16, run_len);
        chk("b2b_no_early_accept", acc_cnt - acc_base, 16);
        run_block(B2, K2, 1'b0, 0, LAT0);

        chk("core_idle_zero", zero_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
